// File: rtl/fetch_unit.sv
// Pipeline front end: PC register, IF/ID register and a circular
// return-address stack with sticky overflow/underflow reporting.
module fetch_unit #(
  parameter int              PC_W      = 8,
  parameter int              INST_W    = 19,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [PC_W-1:0]                imem_addr,
  input  logic [INST_W-1:0]              imem_data,
  input  logic                           stall,
  input  logic                           id_branch_taken,
  input  logic                           id_jump,
  input  logic                           id_call,
  input  logic                           id_ret,
  input  logic [PC_W-1:0]                id_target,
  output logic [INST_W-1:0]              id_instruction,
  output logic [PC_W-1:0]                id_pc_plus_one,
  output logic                           id_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  // Circular pointer helpers; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RAS_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    if (p == '0) return PTR_W'(RAS_DEPTH - 1);
    return p - 1'b1;
  endfunction

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pcp1_q, pcp1_d;
  logic              vld_q, vld_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];

  logic              honor, do_call, do_ret, redirect;
  logic              ras_empty, ras_full;
  logic [PTR_W-1:0]  top_idx;
  logic [PC_W-1:0]   ret_tgt, pc_plus1;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  assign imem_addr      = pc_q;
  assign id_instruction = inst_q;
  assign id_pc_plus_one = pcp1_q;
  assign id_valid       = vld_q;
  assign ras_count      = cnt_q;
  assign ras_overflow   = ovf_q;
  assign ras_underflow  = unf_q;

  // Next-state logic for PC, IF/ID and the stack bookkeeping.
  always_comb begin
    honor     = vld_q & ~stall;
    do_call   = honor & id_call;
    do_ret    = honor & id_ret;
    redirect  = honor & (id_ret | id_jump | id_call | id_branch_taken);
    ras_empty = (cnt_q == '0);
    ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    top_idx   = ptr_dec(wp_q);
    ret_tgt   = ras_empty ? RESET_PC : ras_q[top_idx];
    pc_plus1  = pc_q + 1'b1;

    pc_d   = pc_q;
    inst_d = inst_q;
    pcp1_d = pcp1_q;
    vld_d  = vld_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = wp_q;

    // Stall freezes everything; redirect flushes the wrong-path fetch.
    if (!stall) begin
      if (redirect) begin
        pc_d   = id_ret ? ret_tgt : id_target;
        inst_d = '0;
        pcp1_d = '0;
        vld_d  = 1'b0;
      end else begin
        pc_d   = pc_plus1;
        inst_d = imem_data;
        pcp1_d = pc_plus1;
        vld_d  = 1'b1;
      end
    end

    // Call+ret replaces the top in place; on an empty stack it degrades to a push.
    if (do_call && do_ret) begin
      wr_en = 1'b1;
      if (ras_empty) begin
        wr_idx = wp_q;
        wp_d   = ptr_inc(wp_q);
        cnt_d  = CNT_W'(1);
        unf_d  = 1'b1;
      end else begin
        wr_idx = top_idx;
      end
    end else if (do_call) begin
      wr_en  = 1'b1;
      wr_idx = wp_q;
      wp_d   = ptr_inc(wp_q);
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + 1'b1;
    end else if (do_ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        wp_d  = ptr_dec(wp_q);
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Control and pipeline state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
      pcp1_q <= '0;
      vld_q  <= 1'b0;
      wp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pcp1_q <= pcp1_d;
      vld_q  <= vld_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pcp1_q;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised pipeline front end: PC register, IF/ID pipeline register and a hardware return-address stack (RAS).
Successor to the fixed 8-bit PC / IF_ID / stack-in-register-file arrangement of the current core.
Adds stall, single-cycle flush on redirect, configurable PC/instruction widths, and a RAS of configurable depth with overflow/underflow reporting.
Sits between instruction memory and the decode/control stage; decode returns resolved branch/jump/call/ret decisions for the instruction currently in ID.

Parameters:
PC_W, 8, PC and target width; PC arithmetic is modulo 2^PC_W.
INST_W, 19, instruction width.
RAS_DEPTH, 8, return-address stack entries (>=2).
RESET_PC, 0, PC value after reset and fallback target on RAS underflow.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
imem_addr  output  PC_W  current PC to instruction memory (combinational read).
imem_data  input  INST_W  instruction at imem_addr.
stall  input  1  hazard stall; holds PC and IF/ID.
id_branch_taken  input  1  branch in ID resolved taken.
id_jump  input  1  unconditional jump in ID.
id_call  input  1  ID instruction pushes a return address (implies jump to id_target).
id_ret  input  1  ID instruction returns via RAS.
id_target  input  PC_W  branch/jump/call target.
id_instruction  output  INST_W  IF/ID instruction.
id_pc_plus_one  output  PC_W  IF/ID PC+1.
id_valid  output  1  IF/ID holds a real instruction.
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
ras_overflow  output  1  sticky: push occurred while full.
ras_underflow  output  1  sticky: pop occurred while empty.

Behaviour:
- Reset (async assert, sync-safe deassert): PC=RESET_PC, id_instruction=0, id_pc_plus_one=0, id_valid=0, ras_count=0, both flags 0, RAS storage contents don't-care.
- imem_addr = PC, combinational from the register.
- Redirect controls are honoured only when id_valid=1; otherwise they are ignored.
- Next-PC priority: id_ret > (id_jump | id_call) > id_branch_taken > PC+1.
- Ret target = RAS top; on empty RAS the target is RESET_PC.
- Stall=1: PC, IF/ID and RAS all hold. Stall overrides any redirect; the ID instruction is re-evaluated next cycle.
- No stall, no redirect: PC <= PC+1; IF/ID <= {imem_data, PC+1, valid=1}.
- No stall, redirect: PC <= target. IF/ID is flushed to {0, 0, valid=0}, giving exactly one bubble per redirect. The wrong-path fetch is discarded.
- Push (id_call, honoured): stack top <= id_pc_plus_one; ras_count++.
  - If full, the oldest entry is overwritten (circular); ras_count stays RAS_DEPTH and ras_overflow <= 1.
- Pop (id_ret, honoured): ras_count--.
  - If empty, ras_count stays 0 and ras_underflow <= 1.
- id_call & id_ret together: ret wins the PC, using the old top. The top entry is replaced by id_pc_plus_one and ras_count is unchanged.
  - If the stack was empty, this acts as a push and also sets underflow.
- Flags clear only on reset.
- PC+1 wraps from 2^PC_W-1 to 0 with no flag.
- Latency: redirect takes effect on imem_addr the cycle after it is presented; the first target instruction appears in ID two cycles after.

Test Plan:
- Reset then 4 free cycles, imem[i]=i+100 -> imem_addr 0,1,2,3. id_instruction 100,101,102 with id_valid=1 from cycle 2. Assert reset mid-stream -> all outputs zero immediately.
- Taken branch in ID at PC+1=5, id_target=0x20 -> next imem_addr=0x20. Next cycle id_valid=0. Following cycle id_instruction=imem[0x20], id_pc_plus_one=0x21.
- stall=1 for 3 cycles with id_jump=1 -> PC, IF/ID and ras_count unchanged. Release -> jump taken once, one bubble.
- Call at id_pc_plus_one=0x11 to 0x40, then ret -> ras_count 1 then 0, PC returns to 0x11. Nested 3 calls/3 rets return in LIFO order.
- RAS_DEPTH=4: 5 pushes -> ras_count=4, ras_overflow=1, and 4 pops return the last 4 addresses. A 5th pop -> PC=RESET_PC, ras_underflow=1, ras_count=0.
- PC_W=8 at PC=0xFF without redirect -> next imem_addr=0x00. Simultaneous call+ret with top=0x30 -> PC=0x30, count unchanged, new top=id_pc_plus_one.
